ps2_host_tx: RTL
================

Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. It is the sending counterpart of the keyboard receive path: it sends command bytes to the keyboard, e.g. 0xED set-LEDs or 0xFF reset.
- Sits beside the PS/2 receiver in the top level on the 10 MHz divided clock and drives the shared ps2_clock/ps2_data open-drain lines through pull-low enables.
- While it is busy, the receiver must ignore bus activity.

Parameters:
- CLK_HZ, 10000000, system clock frequency in Hz.
- INHIBIT_CYCLES, 1000, cycles ps2_clock is held low before the start bit (100 us at 10 MHz).
- TIMEOUT_CYCLES, 150000, maximum cycles from clock release to transfer end (15 ms).

Ports:
- clock  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- tx_data  in  8  byte to send, captured on an accepted tx_start.
- tx_start  in  1  single-cycle request; accepted only when busy=0.
- ps2_clk_in  in  1  raw ps2_clock pad value (asynchronous).
- ps2_dat_in  in  1  raw ps2_data pad value (asynchronous).
- ps2_clk_oe  out  1  1 = pull ps2_clock low; 0 = release.
- ps2_dat_oe  out  1  1 = pull ps2_data low; 0 = release.
- busy  out  1  high from the accepted start until done.
- tx_done  out  1  one-cycle pulse at transfer end.
- tx_error  out  1  one-cycle pulse, coincident with tx_done, on missing ACK or timeout.

Behaviour:
- Reset (async, resetn=0):
  - State IDLE.
  - ps2_clk_oe=0, ps2_dat_oe=0, busy=0, tx_done=0, tx_error=0.
  - All counters and the shift register cleared.
  - Reset in mid-transfer releases both lines immediately, without waiting for a clock edge.
- Input sync: each pad is passed through a 2-flop synchronizer. fall = (prev_clk=1 && clk_s=0), evaluated on synchronized values.
- Capture: on tx_start in IDLE, latch shift = {odd_parity, tx_data}, where odd_parity = ~^tx_data. busy rises the next cycle. tx_start while busy=1 is ignored and the latched byte is unchanged.
- State INHIBIT:
  - ps2_clk_oe=1.
  - Count INHIBIT_CYCLES.
  - In the last cycle, set ps2_dat_oe=1 (start bit 0) while clock is still held, then go to REQ.
- State REQ:
  - ps2_clk_oe=0, ps2_dat_oe=1; the timeout counter starts.
  - Move to SEND.
- State SEND, with edge count n (0..9):
  - On each fall, drive the next bit: ps2_dat_oe = ~shift[n].
  - Falls 1-8 carry data LSB first; fall 9 carries parity.
  - Fall 10 releases data (stop bit 1), then go to ACK.
- State ACK:
  - On the next fall (the 11th), sample dat_s.
  - 0 means ACK, so ack_ok=1; 1 means NACK, so ack_ok=0.
  - Go to WAITIDLE.
- State WAITIDLE: wait until clk_s=1 && dat_s=1, then go to DONE.
- State DONE:
  - tx_done=1 for one cycle; tx_error = ~ack_ok.
  - busy=0 in the same cycle; next state IDLE.
- Timeout:
  - Active from REQ through WAITIDLE.
  - When the counter reaches TIMEOUT_CYCLES, release both lines and go to DONE with tx_error=1.
  - Timeout takes priority over a fall in the same cycle.
- Counter widths use $clog2(parameter+1). There is no wrap; counters saturate and are only reset on state entry.
- Device clock pulses before REQ (during INHIBIT) are ignored and not counted.
- A back-to-back tx_start is accepted no earlier than the cycle after tx_done.

Decomposition:
- Shared include ps2_defs.vh:
  - state encodings IDLE, INHIBIT, REQ, SEND, ACK, WAITIDLE, DONE;
  - command constants CMD_SET_LEDS=8'hED, CMD_RESET=8'hFF, RESP_ACK=8'hFA.
- Sub-module ps2_line_sync: 2-flop synchronizer plus falling-edge detector per line, reusable by the receiver.

Test Plan:
- Byte 0xED, device model clocking at 12.5 kHz and ACKing: bits observed on ps2_data at device rising edges are 0, 1,0,1,1,0,1,1,1, parity 1, stop 1. Required: tx_done=1, tx_error=0, busy low after the bus is idle.
- Check inhibit timing: ps2_clk_oe held ≥1000 cycles; ps2_dat_oe=1 before ps2_clk_oe falls.
- Parity: byte 0x01 gives parity 0; 0x00 gives 1; 0xFF gives 1. Each is checked on the 9th device sample.
- Device leaves data high at the 11th fall: tx_done with tx_error=1; both lines released.
- Device never clocks after REQ: after 150000 cycles, tx_done=1 and tx_error=1; oe outputs 0.
- resetn asserted at fall 5: both oe deassert in the same cycle, busy=0. A new tx_start of 0xFF after release completes normally.

Source files
------------

// File: rtl/ps2_host_tx_pkg.sv
// Shared definitions for the PS/2 host transmit path: FSM states, command bytes
// and the 9-bit {odd parity, data} payload builder.
package ps2_host_tx_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        INHIBIT  = 3'd1,
        REQ      = 3'd2,
        SEND     = 3'd3,
        ACK      = 3'd4,
        WAITIDLE = 3'd5,
        DONE     = 3'd6
    } tx_state_e;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] RESP_ACK     = 8'hFA;

    function automatic logic [8:0] ps2_payload(input logic [7:0] data);
        return {~^data, data};
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer with falling-edge detect for one PS/2 pad.
// Flops reset high so an idle bus never looks like a fall out of reset.
module ps2_line_sync (
    input  logic clock,
    input  logic resetn,
    input  logic line_i,
    output logic line_s_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= line_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign line_s_o = sync_q;
    assign fall_o   = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, issues a request-to-send and
// clocks out {data, parity, stop} on device clock falls, then checks the device ACK.
//
// state    | meaning
// IDLE     | lines released, waiting for tx_start
// INHIBIT  | clock held low; start bit asserted in the last cycle
// REQ      | clock released with data low (start bit), timeout armed
// SEND     | next bit driven on each device clock fall
// ACK      | stop bit out; sample device ACK on the next fall
// WAITIDLE | wait for both lines high
// DONE     | one-cycle tx_done / tx_error
module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter int CLK_HZ         = 10000000,
    parameter int INHIBIT_CYCLES = CLK_HZ / 10000,
    parameter int TIMEOUT_CYCLES = (CLK_HZ / 1000) * 15
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_error
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    logic clk_s, clk_fall, dat_s, unused_dat_fall;

    ps2_line_sync u_clk_sync (
        .clock    (clock),
        .resetn   (resetn),
        .line_i   (ps2_clk_in),
        .line_s_o (clk_s),
        .fall_o   (clk_fall)
    );

    ps2_line_sync u_dat_sync (
        .clock    (clock),
        .resetn   (resetn),
        .line_i   (ps2_dat_in),
        .line_s_o (dat_s),
        .fall_o   (unused_dat_fall)
    );

    tx_state_e        state_q, state_d;
    logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [8:0]       shift_q, shift_d;
    logic             dat_oe_q, dat_oe_d;
    logic             ack_ok_q, ack_ok_d;
    logic             timeout;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            inh_cnt_q <= '0;
            to_cnt_q  <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            dat_oe_q  <= 1'b0;
            ack_ok_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            inh_cnt_q <= inh_cnt_d;
            to_cnt_q  <= to_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            dat_oe_q  <= dat_oe_d;
            ack_ok_q  <= ack_ok_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        inh_cnt_d = inh_cnt_q;
        to_cnt_d  = to_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        dat_oe_d  = dat_oe_q;
        ack_ok_d  = ack_ok_q;
        timeout   = 1'b0;

        // Timeout window covers everything after the clock is handed to the device.
        if (state_q inside {REQ, SEND, ACK, WAITIDLE}) begin
            if (to_cnt_q == '0) timeout = 1'b1;
            else                to_cnt_d = to_cnt_q - TO_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (tx_start) begin
                    shift_d   = ps2_payload(tx_data);
                    inh_cnt_d = INH_W'(INHIBIT_CYCLES - 1);
                    bit_cnt_d = '0;
                    ack_ok_d  = 1'b0;
                    dat_oe_d  = 1'b0;
                    state_d   = INHIBIT;
                end
            end
            INHIBIT: begin
                if (inh_cnt_q == '0) begin
                    dat_oe_d = 1'b1;
                    to_cnt_d = TO_W'(TIMEOUT_CYCLES);
                    state_d  = REQ;
                end else begin
                    inh_cnt_d = inh_cnt_q - INH_W'(1);
                end
            end
            REQ: state_d = SEND;
            SEND: begin
                if (clk_fall) begin
                    if (bit_cnt_q == 4'd9) begin
                        dat_oe_d = 1'b0;
                        state_d  = ACK;
                    end else begin
                        dat_oe_d  = ~shift_q[bit_cnt_q];
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            ACK: begin
                if (clk_fall) begin
                    ack_ok_d = ~dat_s;
                    state_d  = WAITIDLE;
                end
            end
            WAITIDLE: if (clk_s && dat_s) state_d = DONE;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase

        if (timeout) begin
            dat_oe_d = 1'b0;
            ack_ok_d = 1'b0;
            state_d  = DONE;
        end
    end

    // Start bit goes low in the final inhibit cycle so data is down before clock releases.
    assign ps2_clk_oe = (state_q == INHIBIT);
    assign ps2_dat_oe = dat_oe_q | ((state_q == INHIBIT) && (inh_cnt_q == '0));
    assign busy       = (state_q != IDLE) && (state_q != DONE);
    assign tx_done    = (state_q == DONE);
    assign tx_error   = (state_q == DONE) && !ack_ok_q;

endmodule
